// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: FSM state codes, coin values
// and the index-width helper used to size table addresses.
package vend_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_PAY    = 3'd2;
  localparam logic [2:0] S_VEND   = 3'd3;
  localparam logic [2:0] S_CHANGE = 3'd4;
  localparam logic [2:0] S_REFUND = 3'd5;

  localparam int COIN_1   = 1;
  localparam int COIN_5   = 5;
  localparam int COIN_10  = 10;
  localparam int COIN_25  = 25;
  localparam int COIN_100 = 100;
  localparam int COIN_500 = 500;

  // Address width for n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vend_item_table.sv
// Per-item price and stock registers with one write port, one registered read
// port and a stock decrement strobe used when an item is dispensed.
module vend_item_table #(
  parameter int NUM_ITEMS = 16,
  parameter int AMT_W     = 16,
  parameter int STOCK_W   = 4,
  parameter int IDX_W     = 4,
  parameter int DEF_PRICE = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [AMT_W-1:0]   wr_price,
  input  logic [STOCK_W-1:0] wr_stock,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [AMT_W-1:0]   rd_price,
  output logic [STOCK_W-1:0] rd_stock,
  input  logic               dec,
  input  logic [IDX_W-1:0]   dec_idx
);

  logic [AMT_W-1:0]   price_r [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_r [NUM_ITEMS];

  // Table storage: writes and dispense decrements never coincide in the controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        price_r[i] <= AMT_W'(DEF_PRICE);
        stock_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (we && (wr_idx == IDX_W'(i))) begin
          price_r[i] <= wr_price;
          stock_r[i] <= wr_stock;
        end else if (dec && (dec_idx == IDX_W'(i)) && (stock_r[i] != '0)) begin
          stock_r[i] <= stock_r[i] - STOCK_W'(1);
        end
      end
    end
  end

  // Registered read; a same-cycle write to the addressed item is forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_price <= '0;
      rd_stock <= '0;
    end else if (we && (wr_idx == rd_idx)) begin
      rd_price <= wr_price;
      rd_stock <= wr_stock;
    end else begin
      rd_price <= price_r[rd_idx];
      rd_stock <= stock_r[rd_idx];
    end
  end

endmodule

// File: rtl/vending_controller.sv
// Clocked vending controller: keypad selection, coin credit, price/stock lookup,
// dispense, change and refund strobes between the front end and the hopper drivers.
module vending_controller
  import vend_pkg::*;
#(
  parameter int  NUM_ROWS    = 4,
  parameter int  NUM_COLS    = 4,
  parameter int  AMT_W       = 16,
  parameter int  STOCK_W     = 4,
  parameter int  TIMEOUT_CYC = 1000,
  parameter int  DEF_PRICE   = 100,
  localparam int IDX_W       = idx_width(NUM_ROWS * NUM_COLS)
) (
  input  logic                I_CLK,
  input  logic                I_RESET_N,
  input  logic [NUM_ROWS-1:0] I_ROW_SEL,
  input  logic [NUM_COLS-1:0] I_COL_SEL,
  input  logic                I_COIN_VALID,
  input  logic [AMT_W-1:0]    I_COIN_VAL,
  input  logic                I_CANCEL,
  input  logic                I_CFG_WE,
  input  logic [IDX_W-1:0]    I_CFG_IDX,
  input  logic [AMT_W-1:0]    I_CFG_PRICE,
  input  logic [STOCK_W-1:0]  I_CFG_STOCK,
  output logic [AMT_W-1:0]    O_CREDIT,
  output logic [AMT_W-1:0]    O_PRICE,
  output logic [IDX_W-1:0]    O_SEL,
  output logic                O_SUCCESS,
  output logic [AMT_W-1:0]    O_CHANGE,
  output logic                O_CHANGE_VALID,
  output logic                O_SOLD_OUT,
  output logic                O_BUSY
);

  localparam int ROW_W = idx_width(NUM_ROWS);
  localparam int COL_W = idx_width(NUM_COLS);
  localparam int TMO_W = idx_width(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [2:0]         state_r, state_nx_s;
  logic [ROW_W-1:0]   row_r, row_enc_s, eff_row_s;
  logic [COL_W-1:0]   col_enc_s;
  logic               row_valid_r, row_hot_s, col_hot_s, sel_s, clear_s;
  logic [IDX_W-1:0]   idx_r, sel_idx_s, sel_r;
  logic [AMT_W-1:0]   credit_r, price_r, change_r, coin_s, credit_sat_s, tbl_price_s;
  logic [AMT_W:0]     credit_sum_s;
  logic [STOCK_W-1:0] tbl_stock_s;
  logic [TMO_W-1:0]   tmo_r;
  logic               success_r, change_valid_r, sold_out_r, busy_r;

  // Keypad decode and saturating credit sum including this cycle's coin.
  always_comb begin
    row_enc_s = '0;
    col_enc_s = '0;
    for (int i = 0; i < NUM_ROWS; i++) row_enc_s = I_ROW_SEL[i] ? ROW_W'(i) : row_enc_s;
    for (int j = 0; j < NUM_COLS; j++) col_enc_s = I_COL_SEL[j] ? COL_W'(j) : col_enc_s;
    row_hot_s    = $onehot(I_ROW_SEL);
    col_hot_s    = $onehot(I_COL_SEL);
    eff_row_s    = row_hot_s ? row_enc_s : row_r;
    sel_s        = col_hot_s && (row_hot_s || row_valid_r);
    sel_idx_s    = IDX_W'(int'(eff_row_s) * NUM_COLS + int'(col_enc_s));
    coin_s       = I_COIN_VALID ? I_COIN_VAL : '0;
    credit_sum_s = {1'b0, credit_r} + {1'b0, coin_s};
    credit_sat_s = credit_sum_s[AMT_W] ? '1 : credit_sum_s[AMT_W-1:0];
  end

  // Next-state logic; in S_PAY a sufficient credit beats reselection, which beats refund.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (sel_s) state_nx_s = S_LOOKUP;
        else if (I_CANCEL && (credit_sat_s != '0)) state_nx_s = S_REFUND;
        else state_nx_s = S_IDLE;
      end
      S_LOOKUP: begin
        if (tbl_stock_s == '0) state_nx_s = S_IDLE;
        else if (credit_r >= tbl_price_s) state_nx_s = S_VEND;
        else state_nx_s = S_PAY;
      end
      S_PAY: begin
        if (credit_r >= price_r) state_nx_s = S_VEND;
        else if (sel_s) state_nx_s = S_LOOKUP;
        else if (I_CANCEL || (!I_COIN_VALID && (tmo_r == TMO_LAST))) state_nx_s = S_REFUND;
        else state_nx_s = S_PAY;
      end
      S_VEND:   state_nx_s = S_CHANGE;
      S_CHANGE: state_nx_s = S_IDLE;
      S_REFUND: state_nx_s = S_IDLE;
      default:  state_nx_s = S_IDLE;
    endcase
    clear_s = (state_nx_s == S_CHANGE) || (state_nx_s == S_REFUND);
  end

  // Transaction registers; the change/refund edge clears credit, price and row.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_r        <= S_IDLE;
      row_r          <= '0;
      row_valid_r    <= 1'b0;
      idx_r          <= '0;
      credit_r       <= '0;
      price_r        <= '0;
      change_r       <= '0;
      sel_r          <= '0;
      success_r      <= 1'b0;
      change_valid_r <= 1'b0;
      sold_out_r     <= 1'b0;
      busy_r         <= 1'b0;
      tmo_r          <= '0;
    end else begin
      state_r        <= state_nx_s;
      success_r      <= (state_nx_s == S_VEND);
      change_valid_r <= clear_s;
      sold_out_r     <= (state_r == S_LOOKUP) && (tbl_stock_s == '0);
      busy_r         <= (state_nx_s != S_IDLE) && (state_nx_s != S_PAY);
      tmo_r          <= ((state_r == S_PAY) && (state_nx_s == S_PAY) && !I_COIN_VALID)
                        ? tmo_r + TMO_W'(1) : '0;
      if (state_nx_s == S_LOOKUP) idx_r <= sel_idx_s;
      if (state_nx_s == S_VEND) sel_r <= idx_r;
      if (clear_s) begin
        row_valid_r <= 1'b0;
      end else if (row_hot_s) begin
        row_r       <= row_enc_s;
        row_valid_r <= 1'b1;
      end
      if (state_nx_s == S_CHANGE) begin
        change_r <= credit_r - price_r;
        credit_r <= coin_s;
        price_r  <= '0;
      end else if (state_nx_s == S_REFUND) begin
        change_r <= credit_sat_s;
        credit_r <= '0;
        price_r  <= '0;
      end else begin
        credit_r <= credit_sat_s;
        if (state_r == S_LOOKUP) price_r <= (tbl_stock_s == '0) ? '0 : tbl_price_s;
      end
    end
  end

  vend_item_table #(
    .NUM_ITEMS (NUM_ROWS * NUM_COLS),
    .AMT_W     (AMT_W),
    .STOCK_W   (STOCK_W),
    .IDX_W     (IDX_W),
    .DEF_PRICE (DEF_PRICE)
  ) u_table (
    .clk      (I_CLK),
    .rst_n    (I_RESET_N),
    .we       (I_CFG_WE && (state_r == S_IDLE) && (credit_r == '0)),
    .wr_idx   (I_CFG_IDX),
    .wr_price (I_CFG_PRICE),
    .wr_stock (I_CFG_STOCK),
    .rd_idx   (sel_idx_s),
    .rd_price (tbl_price_s),
    .rd_stock (tbl_stock_s),
    .dec      (state_r == S_VEND),
    .dec_idx  (idx_r)
  );

  assign O_CREDIT       = credit_r;
  assign O_PRICE        = price_r;
  assign O_SEL          = sel_r;
  assign O_SUCCESS      = success_r;
  assign O_CHANGE       = change_r;
  assign O_CHANGE_VALID = change_valid_r;
  assign O_SOLD_OUT     = sold_out_r;
  assign O_BUSY         = busy_r;

endmodule

// File: tb/tb_vending_controller.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// keypad/coin/config traffic compared every cycle against a transaction-level model.
module tb_vending_controller;
  import vend_pkg::*;

  localparam int NR = 4, NC = 4, TMO = 40, AMT_MAX = 65535;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  row_sel, col_sel;
  logic        coin_valid, cancel, cfg_we;
  logic [15:0] coin_val, cfg_price;
  logic [3:0]  cfg_idx, cfg_stock;
  logic [15:0] o_credit, o_price, o_change;
  logic [3:0]  o_sel;
  logic        o_success, o_change_valid, o_sold_out, o_busy;

  int n_tests = 0, n_fail = 0;

  typedef enum int {P_IDLE, P_LOOKUP, P_PAY, P_VEND, P_CHANGE, P_REFUND} phase_e;
  phase_e m_ph;
  int m_credit, m_price, m_sel, m_change, m_row, m_item, m_wait;
  int m_prc [16];
  int m_stk [16];
  bit e_success, e_cv, e_so, e_busy;

  always #5 clk = ~clk;

  vending_controller #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .AMT_W(16), .STOCK_W(4), .TIMEOUT_CYC(TMO), .DEF_PRICE(100)
  ) dut (
    .I_CLK(clk), .I_RESET_N(rst_n), .I_ROW_SEL(row_sel), .I_COL_SEL(col_sel),
    .I_COIN_VALID(coin_valid), .I_COIN_VAL(coin_val), .I_CANCEL(cancel),
    .I_CFG_WE(cfg_we), .I_CFG_IDX(cfg_idx), .I_CFG_PRICE(cfg_price), .I_CFG_STOCK(cfg_stock),
    .O_CREDIT(o_credit), .O_PRICE(o_price), .O_SEL(o_sel), .O_SUCCESS(o_success),
    .O_CHANGE(o_change), .O_CHANGE_VALID(o_change_valid), .O_SOLD_OUT(o_sold_out), .O_BUSY(o_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_pos(input logic [3:0] v);
    int p = 0;
    for (int i = 0; i < 4; i++) if (v[i]) p = i;
    return p;
  endfunction

  task automatic m_reset();
    m_ph = P_IDLE; m_credit = 0; m_price = 0; m_sel = 0; m_change = 0;
    m_row = -1; m_item = 0; m_wait = 0;
    e_success = 0; e_cv = 0; e_so = 0; e_busy = 0;
    for (int i = 0; i < 16; i++) begin m_prc[i] = 100; m_stk[i] = 0; end
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_step();
    int sum, rpos, item;
    bit rh, sel_ok, clr;
    phase_e nxt;
    sum = m_credit + (coin_valid ? int'(coin_val) : 0);
    if (sum > AMT_MAX) sum = AMT_MAX;
    rh = $onehot(row_sel);
    rpos = rh ? onehot_pos(row_sel) : m_row;
    sel_ok = $onehot(col_sel) && (rpos >= 0);
    item = rpos * NC + onehot_pos(col_sel);
    e_success = 0; e_cv = 0; e_so = 0; clr = 0;
    if (cfg_we && m_ph == P_IDLE && m_credit == 0) begin
      m_prc[cfg_idx] = int'(cfg_price);
      m_stk[cfg_idx] = int'(cfg_stock);
    end
    nxt = m_ph;
    case (m_ph)
      P_IDLE: begin
        if (sel_ok) begin nxt = P_LOOKUP; m_item = item; end
        else if (cancel && sum > 0) nxt = P_REFUND;
      end
      P_LOOKUP: begin
        if (m_stk[m_item] == 0) begin e_so = 1; m_price = 0; nxt = P_IDLE; end
        else begin
          m_price = m_prc[m_item]; m_wait = 0;
          nxt = (m_credit >= m_price) ? P_VEND : P_PAY;
        end
      end
      P_PAY: begin
        if (m_credit >= m_price) nxt = P_VEND;
        else if (sel_ok) begin nxt = P_LOOKUP; m_item = item; end
        else if (cancel || (!coin_valid && m_wait == TMO - 1)) nxt = P_REFUND;
        else m_wait = coin_valid ? 0 : m_wait + 1;
      end
      P_VEND: begin
        nxt = P_CHANGE; m_stk[m_item]--; e_cv = 1; clr = 1;
        m_change = m_credit - m_price;
        sum = coin_valid ? int'(coin_val) : 0;
      end
      default: nxt = P_IDLE;
    endcase
    if (nxt == P_VEND) begin e_success = 1; m_sel = m_item; end
    if (nxt == P_REFUND) begin e_cv = 1; m_change = sum; sum = 0; clr = 1; end
    if (clr) begin m_price = 0; m_row = -1; end
    else if (rh) m_row = onehot_pos(row_sel);
    m_credit = sum;
    m_ph = nxt;
    e_busy = (nxt == P_LOOKUP) || (nxt == P_VEND) || (nxt == P_CHANGE) || (nxt == P_REFUND);
  endtask

  task automatic compare();
    chk("credit", o_credit, m_credit);
    chk("price", o_price, m_price);
    chk("sel", o_sel, m_sel);
    chk("success", o_success, e_success);
    chk("change_valid", o_change_valid, e_cv);
    chk("change", o_change, m_change);
    chk("sold_out", o_sold_out, e_so);
    chk("busy", o_busy, e_busy);
  endtask

  task automatic clear_inputs();
    row_sel = '0; col_sel = '0; coin_valid = 1'b0; coin_val = '0; cancel = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_price = '0; cfg_stock = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
    clear_inputs();
  endtask

  task automatic coin(input int v); coin_valid = 1'b1; coin_val = 16'(v); step(); endtask
  task automatic press_row(input int r); row_sel = 4'(1 << r); step(); endtask
  task automatic press_col(input int c); col_sel = 4'(1 << c); step(); endtask
  task automatic do_cancel(); cancel = 1'b1; step(); endtask
  task automatic cfg(input int idx, input int price, input int stock);
    cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_price = 16'(price); cfg_stock = 4'(stock); step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_credit"}, o_credit, 0);   chk({tag, "_price"}, o_price, 0);
    chk({tag, "_sel"}, o_sel, 0);         chk({tag, "_success"}, o_success, 0);
    chk({tag, "_change"}, o_change, 0);   chk({tag, "_cv"}, o_change_valid, 0);
    chk({tag, "_sold_out"}, o_sold_out, 0); chk({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    int coins [6];
    int r;
    coins = '{COIN_1, COIN_5, COIN_10, COIN_25, COIN_100, COIN_500};
    clear_inputs();
    m_reset();
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: exact credit, zero change, latency 2/3 cycles after column press
    cfg(0, 100, 5);
    repeat (4) coin(COIN_25);
    chk("t1_credit", o_credit, 100);
    press_row(0); press_col(0);
    chk("t1_busy_lookup", o_busy, 1);
    step(); chk("t1_success", o_success, 1); chk("t1_sel", o_sel, 0);
    step(); chk("t1_cv", o_change_valid, 1); chk("t1_change", o_change, 0); chk("t1_credit0", o_credit, 0);
    step();

    // T2: insufficient credit waits in S_PAY, completes on the next coin
    cfg(5, 250, 3);
    coin(COIN_100); coin(COIN_100);
    press_row(1); press_col(1);
    step(); chk("t2_price", o_price, 250); chk("t2_busy_pay", o_busy, 0);
    coin(COIN_100);
    step(); chk("t2_success", o_success, 1); chk("t2_sel", o_sel, 5);
    step(); chk("t2_cv", o_change_valid, 1); chk("t2_change", o_change, 50);
    step();

    // T3: last row press wins
    cfg(15, 200, 2);
    repeat (4) coin(COIN_100);
    press_row(0); press_row(1); press_row(3); press_col(3);
    step(); chk("t3_success", o_success, 1); chk("t3_sel", o_sel, 15);
    step(); chk("t3_change", o_change, 200); chk("t3_credit0", o_credit, 0);
    step();

    // T4: sold out keeps credit; then idle cancel refunds it
    cfg(8, 120, 0);
    coin(COIN_100); coin(COIN_25); coin(COIN_25);
    press_row(2); press_col(0);
    step(); chk("t4_sold_out", o_sold_out, 1); chk("t4_price", o_price, 0);
    chk("t4_credit", o_credit, 150); chk("t4_no_vend", o_success, 0);
    do_cancel(); chk("t4_refund_cv", o_change_valid, 1); chk("t4_refund", o_change, 150);
    step();

    // T5: coin plus cancel in S_PAY, then inactivity timeout
    repeat (3) coin(COIN_25);
    press_row(1); press_col(1); step();
    coin_valid = 1'b1; coin_val = 16'(COIN_25); cancel = 1'b1; step();
    chk("t5_cancel_cv", o_change_valid, 1); chk("t5_cancel_refund", o_change, 100);
    step();
    repeat (3) coin(COIN_25);
    press_row(1); press_col(1); step();
    repeat (TMO - 1) step();
    chk("t5_no_early_timeout", o_change_valid, 0);
    step(); chk("t5_timeout_cv", o_change_valid, 1); chk("t5_timeout_refund", o_change, 75);
    step();

    // T6: config dropped with credit held; async reset in S_PAY
    coin(COIN_10);
    cfg(0, 7, 9);
    do_cancel(); chk("t6_refund", o_change, 10);
    step();
    press_row(0); press_col(0); step();
    chk("t6_price_unchanged", o_price, 100);
    step();
    rst_n = 1'b0;
    #2;
    chk_all_zero("t6_reset");
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Credit saturation and its full refund
    repeat (132) coin(COIN_500);
    chk("sat_credit", o_credit, AMT_MAX);
    do_cancel(); chk("sat_refund", o_change, AMT_MAX);
    step();

    // Random traffic against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r = $urandom_range(0, 99);
      row_sel = (r < 15) ? 4'(1 << $urandom_range(0, 3)) : ((r < 18) ? 4'($urandom) : 4'b0);
      r = $urandom_range(0, 99);
      col_sel = (r < 12) ? 4'(1 << $urandom_range(0, 3)) : ((r < 14) ? 4'($urandom) : 4'b0);
      coin_valid = ($urandom_range(0, 99) < 20);
      coin_val = coin_valid ? 16'(coins[$urandom_range(0, 5)]) : 16'd0;
      cancel = ($urandom_range(0, 99) < 3);
      cfg_we = ($urandom_range(0, 99) < 8);
      cfg_idx = 4'($urandom_range(0, 15));
      cfg_price = 16'($urandom_range(0, 400));
      cfg_stock = 4'($urandom_range(0, 3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
